// File: rtl/pool_frame_sched.sv
// Frame scheduler for the max-pool row datapath: sequences ce/sel/load_sr/rst_m/op_en
// over P-row bands, feature maps and channels. Optional stall counter: POOL_FRAME_SCHED_PERF_EN.
module pool_frame_sched #(
  parameter int M      = 6,
  parameter int P      = 2,
  parameter int N_ROWS = 6,
  parameter int CH     = 1,
  parameter int CW     = 9
) (
  input  logic        clk,
  input  logic        master_rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        ce,
  output logic [1:0]  sel,
  output logic        load_sr,
  output logic        rst_m,
  output logic        op_en,
  output logic        busy,
  output logic        frame_done
`ifdef POOL_FRAME_SCHED_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  if ((M % P) != 0 || (N_ROWS % P) != 0) begin : g_cfg_err
    $error("pool_frame_sched: M and N_ROWS must be multiples of P");
  end

  localparam logic [CW-1:0] P_C       = CW'(P);
  localparam logic [CW-1:0] P_LAST    = CW'(P - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(M - 1);
  localparam logic [CW-1:0] BAND_LAST = CW'(N_ROWS / P - 1);
  localparam logic [CW-1:0] CHN_LAST  = CW'(CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col, rib, band, chn, ph;
  logic          col_end, rib_end, band_end, chn_end;
  logic          close_win, last_win, last_pend;

  assign ph       = col % P_C;
  assign col_end  = (col == COL_LAST);
  assign rib_end  = (rib == P_LAST);
  assign band_end = (band == BAND_LAST);
  assign chn_end  = (chn == CHN_LAST);

  // An unacknowledged result blocks input; the final result also blocks the next beat.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy     = 1'b1;
        in_ready = !(op_en && (!out_ready || last_pend));
        if (op_en && out_ready && last_pend) state_nx = DONE;
        else if (op_en && !out_ready)        state_nx = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (out_ready) state_nx = last_pend ? DONE : RUN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ce      = in_valid && in_ready;
    sel     = 2'b00;
    load_sr = 1'b0;
    if (ce) begin
      if (ph == '0) sel = (rib == '0) ? 2'b10 : 2'b01;
      load_sr = (ph == P_LAST);
    end
    close_win = load_sr && rib_end;
    rst_m     = close_win;
    last_win  = close_win && col_end && band_end && chn_end;
  end

  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      state      <= IDLE;
      op_en      <= 1'b0;
      frame_done <= 1'b0;
      last_pend  <= 1'b0;
      col        <= '0;
      rib        <= '0;
      band       <= '0;
      chn        <= '0;
    end else begin
      state      <= state_nx;
      op_en      <= close_win || (op_en && !out_ready);
      frame_done <= (state == DONE);
      if (last_win)                last_pend <= 1'b1;
      else if (op_en && out_ready) last_pend <= 1'b0;
      if (ce) begin
        if (!col_end) begin
          col <= col + 1'b1;
        end else begin
          col <= '0;
          if (!rib_end) begin
            rib <= rib + 1'b1;
          end else begin
            rib <= '0;
            if (!band_end) begin
              band <= band + 1'b1;
            end else begin
              band <= '0;
              chn  <= chn_end ? '0 : chn + 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef POOL_FRAME_SCHED_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n)                 stall_cnt <= '0;
    else if (state == IDLE && start)   stall_cnt <= '0;
    else if (busy && !in_ready)        stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule
